// File: rtl/vid_pkg.sv
// vid_pkg: shared types for the video line fetcher.
// FSM state encoding, CFG_REP codes and repeat-count helper.
package vid_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] REP_1  = 2'b00;
  localparam logic [1:0] REP_2  = 2'b01;
  localparam logic [1:0] REP_4  = 2'b10;
  localparam logic [1:0] REP_4B = 2'b11;

  function automatic logic [2:0] rep_count(input logic [1:0] code);
    logic [2:0] n;
    unique case (code)
      REP_1:   n = 3'd1;
      REP_2:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vid_fifo.sv
// vid_fifo: small synchronous pixel FIFO with flush.
// Push when full and pop when empty are ignored.
module vid_fifo
  import vid_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PIX_W = 6,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic do_push;
  logic do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointers and occupancy; push+pop together keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vid_fetch.sv
// vid_fetch: fetches a video line from RAM into a FIFO and
// replays pixels on PIX_STB. VID_FETCH_UNDERRUN_EN adds UNDERRUN.
module vid_fetch
  import vid_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 6,
  parameter int DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CFG_WE,
  input  logic [ADDR_W-1:0] CFG_ADDR,
  input  logic [7:0]        CFG_LEN,
  input  logic [1:0]        CFG_REP,
  input  logic              LINE_START,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_GNT,
  input  logic [7:0]        MEM_DATA,
  input  logic              PIX_STB,
  output logic [PIX_W-1:0]  PIX_OUT,
  output logic              PIX_VALID,
  output logic              BUSY,
  output logic              UNDERRUN
);

  localparam int AW = $clog2(DEPTH);

  state_t state;
  logic [ADDR_W-1:0] sh_addr;
  logic [ADDR_W-1:0] faddr;
  logic [7:0] sh_len;
  logic [7:0] fcnt;
  logic [1:0] sh_rep;
  logic [2:0] rep_n;
  logic [1:0] rcnt;
  logic pend;

  logic [ADDR_W-1:0] eff_addr;
  logic [7:0] eff_len;
  logic [1:0] eff_rep;
  logic room, gnt, push, pop, take, starve;
  logic last_rep, fetch_done;
  logic [PIX_W-1:0] head;
  logic empty, full;
  logic [AW:0] count;
  logic unused_bits;

  assign eff_addr = CFG_WE ? CFG_ADDR : sh_addr;
  assign eff_len  = CFG_WE ? CFG_LEN : sh_len;
  assign eff_rep  = CFG_WE ? CFG_REP : sh_rep;

  assign BUSY     = (state != S_IDLE);
  assign room     = (int'(count) + int'(pend)) < DEPTH;
  assign MEM_REQ  = (state == S_FETCH) && (fcnt != 8'd0) && room;
  assign MEM_ADDR = faddr;
  assign gnt      = MEM_REQ & MEM_GNT;

  assign push       = pend & ~LINE_START;
  assign last_rep   = ({1'b0, rcnt} == (rep_n - 3'd1));
  assign take       = PIX_STB & BUSY & ~empty & ~LINE_START;
  assign starve     = PIX_STB & BUSY & empty & ~LINE_START;
  assign pop        = take & last_rep;
  assign fetch_done = (fcnt == 8'd0) && !pend;

  assign unused_bits = ^{MEM_DATA, full};

  vid_fifo #(.DEPTH(DEPTH), .PIX_W(PIX_W)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .flush (LINE_START),
    .din   (MEM_DATA[PIX_W-1:0]),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  // Shadow configuration, consumed at LINE_START.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_addr <= '0;
      sh_len  <= '0;
      sh_rep  <= REP_1;
    end else if (CFG_WE) begin
      sh_addr <= CFG_ADDR;
      sh_len  <= CFG_LEN;
      sh_rep  <= CFG_REP;
    end
  end

  // Line FSM, fetch address/count and outstanding-read tracking.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      faddr <= '0;
      fcnt  <= '0;
      pend  <= 1'b0;
      rep_n <= 3'd1;
    end else if (LINE_START) begin
      pend <= 1'b0;
      if (eff_len != 8'd0) begin
        state <= S_FETCH;
        faddr <= eff_addr;
        fcnt  <= eff_len;
        rep_n <= rep_count(eff_rep);
      end else begin
        state <= S_IDLE;
      end
    end else begin
      pend <= gnt;
      if (gnt) begin
        faddr <= faddr + ADDR_W'(1);
        fcnt  <= fcnt - 8'd1;
      end
      unique case (state)
        S_FETCH: if (fetch_done) state <= S_DRAIN;
        S_DRAIN: begin
          if (empty || (pop && count == (AW+1)'(1)))
            state <= S_IDLE;
        end
        default: state <= state;
      endcase
    end
  end

  // Pixel output; the last pixel stays up one cycle after its strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PIX_OUT   <= '0;
      PIX_VALID <= 1'b0;
      rcnt      <= '0;
    end else if (LINE_START) begin
      rcnt <= '0;
    end else if (!BUSY) begin
      PIX_OUT   <= '0;
      PIX_VALID <= 1'b0;
      rcnt      <= '0;
    end else if (take) begin
      PIX_OUT   <= head;
      PIX_VALID <= 1'b1;
      rcnt      <= last_rep ? 2'd0 : rcnt + 2'd1;
    end else if (starve) begin
      PIX_OUT   <= '0;
      PIX_VALID <= 1'b0;
    end
  end

`ifdef VID_FETCH_UNDERRUN_EN
  logic und;

  // Sticky starvation flag, cleared by a config write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         und <= 1'b0;
    else if (CFG_WE) und <= 1'b0;
    else if (starve) und <= 1'b1;
  end

  assign UNDERRUN = und;
`else
  assign UNDERRUN = 1'b0;
`endif

endmodule

// File: doc/vid_fetch.md
VID_FETCH -- requirements
Module: vid_fetch

Interface
REQ-001 Parameter ADDR_W, default 19, SHALL set the RAM address width.
REQ-002 Parameter PIX_W, default 6, SHALL set the pixel width; PIX_W is 8 or less.
REQ-003 Parameter DEPTH, default 8, SHALL set the FIFO depth; DEPTH is a power of two and at least 2.
REQ-004 CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 RST  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 CFG_WE  in  1  SHALL be the configuration write strobe.
REQ-007 CFG_ADDR  in  ADDR_W  SHALL carry the line start address.
REQ-008 CFG_LEN  in  8  SHALL carry the pixels per line; 0 disables fetching.
REQ-009 CFG_REP  in  2  SHALL carry the pixel repeat: 00=1, 01=2, 10=4, 11=4.
REQ-010 LINE_START  in  1  SHALL be a one-cycle pulse that begins a line.
REQ-011 MEM_REQ  out  1  SHALL request a RAM read slot.
REQ-012 MEM_ADDR  out  ADDR_W  SHALL carry the read address.
REQ-013 MEM_GNT  in  1  SHALL grant the current request.
REQ-014 MEM_DATA  in  8  SHALL carry read data, valid exactly one cycle after MEM_GNT.
REQ-015 PIX_STB  in  1  SHALL be the pixel clock-enable from the video timing.
REQ-016 PIX_OUT  out  PIX_W  SHALL carry the current pixel.
REQ-017 PIX_VALID  out  1  SHALL mark PIX_OUT as driven from fetched data.
REQ-018 BUSY  out  1  SHALL be high in any state other than IDLE.
REQ-019 UNDERRUN  out  1  SHALL be a sticky FIFO-starvation flag.

Function
REQ-020 CFG_WE SHALL latch ADDR/LEN/REP into shadow registers.
- Shadow values are used only at the next accepted LINE_START.
- CFG_WE in the same cycle as LINE_START SHALL use the new values.
REQ-021 The FSM SHALL have the states IDLE, FETCH and DRAIN.
- IDLE->FETCH on LINE_START with shadow LEN!=0; the fetch address and fetch count (=LEN) are loaded.
- LINE_START with LEN==0 SHALL leave the FSM in IDLE.
REQ-022 In FETCH, MEM_REQ SHALL equal (fetch count!=0) AND (FIFO occupancy + outstanding read < DEPTH).
- MEM_ADDR SHALL be stable while MEM_REQ is high and no grant has occurred.
REQ-023 On MEM_GNT with MEM_REQ high:
- fetch address SHALL increment by 1, wrapping modulo 2^ADDR_W;
- fetch count SHALL decrement by 1.
MEM_GNT without MEM_REQ SHALL be ignored.
REQ-024 One cycle after an accepted grant, MEM_DATA[PIX_W-1:0] SHALL be pushed into the FIFO.
REQ-025 FETCH->DRAIN SHALL occur when the fetch count reaches 0 and no read is outstanding.
REQ-026 DRAIN->IDLE SHALL occur on the PIX_STB that consumes the final repeat of the last pixel.
REQ-027 On PIX_STB with the FIFO non-empty:
- PIX_OUT SHALL take the FIFO head;
- PIX_VALID SHALL go to 1;
- the repeat counter SHALL advance;
- the FIFO SHALL pop after REP strobes of the same pixel.
Latency from LINE_START to first PIX_VALID is 3 cycles minimum (request, grant, push) plus one PIX_STB.
REQ-028 On PIX_STB with the FIFO empty while BUSY, PIX_OUT SHALL be 0 and PIX_VALID SHALL be 0.
REQ-029 In IDLE, PIX_OUT and PIX_VALID SHALL hold 0.
REQ-030 LINE_START while BUSY SHALL abort the current line:
- flush the FIFO and repeat counter;
- discard any outstanding read's data;
- restart per REQ-021 in the same cycle.
REQ-031 A simultaneous FIFO push and pop SHALL leave the occupancy unchanged; the FIFO never overflows (guaranteed by REQ-022).

Reset
REQ-032 RST SHALL force, asynchronously:
- state=IDLE, MEM_REQ=0, MEM_ADDR=0, PIX_OUT=0, PIX_VALID=0, UNDERRUN=0;
- FIFO empty, counters 0;
- shadow ADDR=0, LEN=0, REP=00.
REQ-033 RST asserted mid-line SHALL abandon the line; read data arriving after reset release SHALL be ignored.

Configuration
REQ-034 With VID_FETCH_UNDERRUN_EN defined:
- UNDERRUN SHALL set on any REQ-028 event;
- UNDERRUN SHALL clear only on RST or on CFG_WE.
Without VID_FETCH_UNDERRUN_EN, UNDERRUN SHALL be tied to 0 and no detection logic is synthesised.

Structure
REQ-035 Package vid_pkg SHALL hold:
- the FSM state enum (IDLE/FETCH/DRAIN);
- the CFG_REP encoding constants;
- a function mapping REP code to repeat count.
REQ-036 The FIFO SHALL be the single sub-module vid_fifo (parameters DEPTH, PIX_W; push/pop/flush, empty/full/count outputs).

Verification
REQ-037 The bench SHALL cover the following scenarios:
- CFG ADDR=0x100, LEN=4, REP=00; LINE_START; GNT always 1 -> MEM_ADDR 0x100..0x103; pixels D0..D3 on four consecutive PIX_STB; then IDLE.
- REP=10, LEN=2 -> each pixel appears on 4 consecutive PIX_STB; pops after the 4th; BUSY drops after the 8th strobe.
- DEPTH=8, LEN=20, PIX_STB held 0 -> MEM_REQ drops after 8 grants; resumes after the first pop.
- ADDR=0x7FFFF, LEN=2 -> MEM_ADDR 0x7FFFF then 0x00000.
- GNT delayed 10 cycles, PIX_STB every cycle:
  - with VID_FETCH_UNDERRUN_EN, UNDERRUN=1 and PIX_VALID=0 during starvation;
  - with CFG_WE, UNDERRUN clears.
- LINE_START mid-line with 3 pixels buffered -> FIFO flushed; next MEM_ADDR = new start address; stale read data is not output.
